packet_scheduler: RTL and testbench

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/packet_scheduler_pkg.sv | 22 ++
 rtl/packet_scheduler_gap_timer.sv | 37 +++
 rtl/packet_scheduler.sv | 172 +++++++++++++++++
 tb/tb_packet_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_scheduler_pkg.sv
// Shared types and default sizing for the video/audio packet scheduler.
package packet_scheduler_pkg;

   localparam int ADDR_W          = 17;
   localparam int DEF_PIX_PER_PKT = 320;
   localparam int DEF_FRAME_PIX   = 76800;
   localparam int DEF_GAP_CYC     = 48;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARB       = 3'd1,
      ST_LAUNCH    = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } state_e;

   typedef enum logic {
      KIND_VIDEO = 1'b0,
      KIND_AUDIO = 1'b1
   } kind_e;

endpackage

// File: rtl/packet_scheduler_gap_timer.sv
// Loadable down-counter; counts to zero and holds there. Shared by the
// inter-packet gap and the serializer timeout.
module gap_timer #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: a load wins, otherwise decrement until zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/packet_scheduler.sv
// Packet scheduler: interleaves video packets of a frame with audio packets,
// spaces packets by a fixed gap and guards the serializer with a timeout.
module packet_scheduler
   import packet_scheduler_pkg::*;
#(
   parameter int PIX_PER_PKT = DEF_PIX_PER_PKT,
   parameter int FRAME_PIX   = DEF_FRAME_PIX,
   parameter int GAP_CYC     = DEF_GAP_CYC,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_req,
   input  logic              audio_ready,
   input  logic              tx_done,
   output logic              tx_start,
   output logic              tx_kind,
   output logic [ADDR_W-1:0] tx_addr,
   output logic              audio_ack,
   output logic              frame_busy,
   output logic              frame_done,
   output logic              err_timeout
);

   localparam int TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   state_e            state_q;
   kind_e             kind_q;
   logic              tx_start_q;
   logic [ADDR_W-1:0] tx_addr_q;
   logic              audio_ack_q;
   logic              frame_busy_q;
   logic              frame_done_q;
   logic              err_timeout_q;
   logic [ADDR_W-1:0] addr_q;
   logic              pend_q;
   logic              last_audio_q;

   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_zero;
   logic [ADDR_W-1:0] addr_adv;
   logic              video_done;
   logic              frame_end;
   logic              pick_audio;

   gap_timer #(.W(TMR_W)) u_gap_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .zero_o    (tmr_zero)
   );

   assign addr_adv   = addr_q + ADDR_W'(PIX_PER_PKT);
   assign video_done = (state_q == ST_WAIT_DONE) && tx_done && (kind_q == KIND_VIDEO);
   assign frame_end  = video_done && (addr_adv == ADDR_W'(FRAME_PIX));
   // Audio wins unless it just went out while a frame still needs service.
   assign pick_audio = audio_ready && (!last_audio_q || !frame_busy_q);

   // Timer loads: timeout window on launch, gap on completion or timeout.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      if (state_q == ST_LAUNCH) begin
         tmr_load = 1'b1;
         tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
      end else if ((state_q == ST_WAIT_DONE) && (tx_done || tmr_zero)) begin
         tmr_load = 1'b1;
         tmr_val  = TMR_W'(GAP_CYC - 1);
      end
   end

   // Scheduler FSM with frame bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         kind_q        <= KIND_VIDEO;
         tx_start_q    <= 1'b0;
         tx_addr_q     <= '0;
         audio_ack_q   <= 1'b0;
         frame_busy_q  <= 1'b0;
         frame_done_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         addr_q        <= '0;
         pend_q        <= 1'b0;
         last_audio_q  <= 1'b0;
      end else begin
         tx_start_q   <= 1'b0;
         audio_ack_q  <= 1'b0;
         frame_done_q <= 1'b0;

         // A completing frame restarts at once if a request is waiting or
         // arrives in that very cycle; otherwise requests start or queue.
         if (frame_end) begin
            addr_q       <= '0;
            frame_done_q <= 1'b1;
            if (pend_q || frame_req) begin
               pend_q <= 1'b0;
            end else begin
               frame_busy_q <= 1'b0;
            end
         end else begin
            if (video_done) begin
               addr_q <= addr_adv;
            end
            if (frame_req) begin
               if (frame_busy_q) begin
                  pend_q <= 1'b1;
               end else begin
                  frame_busy_q <= 1'b1;
                  addr_q       <= '0;
               end
            end
         end

         unique case (state_q)
            ST_IDLE: begin
               if (frame_busy_q || audio_ready) begin
                  state_q <= ST_ARB;
               end
            end
            ST_ARB: begin
               if (pick_audio) begin
                  state_q      <= ST_LAUNCH;
                  kind_q       <= KIND_AUDIO;
                  tx_start_q   <= 1'b1;
                  audio_ack_q  <= 1'b1;
                  last_audio_q <= 1'b1;
               end else if (frame_busy_q) begin
                  state_q      <= ST_LAUNCH;
                  kind_q       <= KIND_VIDEO;
                  tx_start_q   <= 1'b1;
                  tx_addr_q    <= addr_q;
                  last_audio_q <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               state_q <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (tx_done) begin
                  state_q <= ST_GAP;
               end else if (tmr_zero) begin
                  err_timeout_q <= 1'b1;
                  state_q       <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (tmr_zero) begin
                  state_q <= ST_ARB;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_start    = tx_start_q;
   assign tx_kind     = kind_q;
   assign tx_addr     = tx_addr_q;
   assign audio_ack   = audio_ack_q;
   assign frame_busy  = frame_busy_q;
   assign frame_done  = frame_done_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Self-checking bench for packet_scheduler: randomized serializer delays and
// frame/audio traffic checked against an event-level reference model.
module tb_packet_scheduler;

   localparam int PIX = 320;
   localparam int FRM = 76800;
   localparam int GAP = 48;
   localparam int TMO = 4096;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_req;
   logic        audio_ready;
   logic        tx_done;
   logic        tx_start;
   logic        tx_kind;
   logic [16:0] tx_addr;
   logic        audio_ack;
   logic        frame_busy;
   logic        frame_done;
   logic        err_timeout;

   packet_scheduler #(
      .PIX_PER_PKT(PIX),
      .FRAME_PIX  (FRM),
      .GAP_CYC    (GAP),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_req  (frame_req),
      .audio_ready(audio_ready),
      .tx_done    (tx_done),
      .tx_start   (tx_start),
      .tx_kind    (tx_kind),
      .tx_addr    (tx_addr),
      .audio_ack  (audio_ack),
      .frame_busy (frame_busy),
      .frame_done (frame_done),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int now    = 0;
   int t_done = 0;

   // Reference model: frame progress as plain integers.
   bit m_busy       = 1'b0;
   bit m_pend       = 1'b0;
   bit m_last_audio = 1'b0;
   int m_addr       = 0;

   // Pulse counters observed on the falling edge.
   int n_start  = 0;
   int n_astart = 0;
   int n_ack    = 0;
   int n_fd     = 0;

   always @(negedge clk) begin
      if (tx_start === 1'b1) n_start++;
      if (tx_start === 1'b1 && tx_kind === 1'b1) n_astart++;
      if (audio_ack === 1'b1) n_ack++;
      if (frame_done === 1'b1) n_fd++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic finish_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   task automatic tick();
      @(negedge clk);
      now++;
   endtask

   task automatic model_req();
      if (m_busy) begin
         m_pend = 1'b1;
      end else begin
         m_busy = 1'b1;
         m_addr = 0;
      end
   endtask

   task automatic model_done(input bit vid, input bit creq, output bit fd);
      fd = 1'b0;
      if (vid) begin
         m_addr += PIX;
         if (m_addr == FRM) begin
            m_addr = 0;
            fd     = 1'b1;
            if (m_pend || creq) m_pend = 1'b0;
            else                m_busy = 1'b0;
         end
      end
      if (creq && !fd) model_req();
   endtask

   task automatic wait_start();
      bit ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         tick();
         if (tx_start === 1'b1) ok = 1'b1;
      end
      chk("start_seen", ok, 1);
      if (!ok) finish_run();
   endtask

   // One packet: wait for launch, check it, answer tx_done after dly cycles.
   // req_mode 1 = frame_req mid-packet, 2 = frame_req together with tx_done.
   task automatic step_pkt(input int dly, input int req_mode, input bit chk_lat,
                           output int kind);
      bit exp_fd;
      wait_start();
      if (chk_lat) chk("gap_latency", now - t_done, GAP + 2);
      kind = (audio_ready && !m_last_audio) ? 1 : (m_busy ? 0 : 1);
      chk("tx_kind", tx_kind, kind);
      chk("audio_ack", audio_ack, kind);
      if (kind == 0) chk("tx_addr", tx_addr, m_addr);
      m_last_audio = (kind == 1);
      for (int i = 1; i <= dly; i++) begin
         tick();
         frame_req = 1'b0;
         if (i == 1) chk("start_one_cycle", tx_start, 0);
         if (i == 1 && req_mode == 1) begin
            frame_req = 1'b1;
            model_req();
         end
      end
      tx_done = 1'b1;
      t_done  = now;
      if (req_mode == 2) frame_req = 1'b1;
      tick();
      tx_done   = 1'b0;
      frame_req = 1'b0;
      model_done(kind == 0, req_mode == 2, exp_fd);
      chk("frame_done", frame_done, exp_fd);
      chk("frame_busy", frame_busy, m_busy);
   endtask

   initial begin
      int kind;
      int snap;
      int addr_a;
      rst_n       = 1'b0;
      frame_req   = 1'b0;
      audio_ready = 1'b0;
      tx_done     = 1'b0;

      // Reset state.
      tick(); tick();
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_kind", tx_kind, 0);
      chk("rst_tx_addr", tx_addr, 0);
      chk("rst_audio_ack", audio_ack, 0);
      chk("rst_frame_busy", frame_busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_err_timeout", err_timeout, 0);
      rst_n = 1'b1;
      repeat (10) tick();
      chk("idle_no_start", n_start, 0);

      // Frame 1: fixed 10-cycle serializer; a request coincides with the
      // completing tx_done so frame 2 follows straight away.
      snap      = n_start;
      frame_req = 1'b1;
      model_req();
      tick();
      frame_req = 1'b0;
      for (int i = 0; i < 240; i++) step_pkt(10, (i == 239) ? 2 : 0, i > 0, kind);
      tick();
      chk("frame1_starts", n_start - snap, 240);
      chk("frame1_done_cnt", n_fd, 1);

      // Frame 2: random delays, two requests mid-frame -> exactly one more.
      for (int i = 0; i < 240; i++)
         step_pkt($urandom_range(2, 20), (i == 40 || i == 100) ? 1 : 0, 1'b1, kind);
      // Frame 3: the single pending request.
      for (int i = 0; i < 240; i++) step_pkt($urandom_range(2, 20), 0, 1'b1, kind);
      snap = n_start;
      repeat (150) tick();
      chk("no_extra_frame", n_start - snap, 0);
      chk("idle_busy", frame_busy, 0);
      chk("frame_done_total", n_fd, 3);

      // Reset while the packet at address 640 is outstanding.
      frame_req = 1'b1;
      model_req();
      tick();
      frame_req = 1'b0;
      step_pkt(5, 0, 1'b0, kind);
      step_pkt(5, 0, 1'b1, kind);
      wait_start();
      chk("pre_rst_kind", tx_kind, 0);
      chk("pre_rst_addr", tx_addr, 640);
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tx_start", tx_start, 0);
      chk("arst_tx_kind", tx_kind, 0);
      chk("arst_tx_addr", tx_addr, 0);
      chk("arst_audio_ack", audio_ack, 0);
      chk("arst_frame_busy", frame_busy, 0);
      chk("arst_frame_done", frame_done, 0);
      chk("arst_err_timeout", err_timeout, 0);
      m_busy       = 1'b0;
      m_pend       = 1'b0;
      m_addr       = 0;
      m_last_audio = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      frame_req = 1'b1;
      model_req();
      tick();
      frame_req = 1'b0;
      step_pkt(6, 0, 1'b0, kind);
      chk("post_rst_first_video", kind, 0);

      // Audio held high during the frame: strict alternation, first audio.
      audio_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step_pkt($urandom_range(1, 15), 0, 1'b1, kind);
         chk("alternate_kind", kind, (i % 2 == 0) ? 1 : 0);
      end
      audio_ready = 1'b0;
      tick();
      chk("audio_starts", n_astart, 4);
      chk("audio_ack_count", n_ack, n_astart);

      // Timeout: withhold tx_done, then a stray tx_done in GAP is ignored.
      wait_start();
      chk("tmo_latency", now - t_done, GAP + 2);
      chk("tmo_kind", tx_kind, 0);
      chk("tmo_addr", tx_addr, m_addr);
      addr_a       = m_addr;
      m_last_audio = 1'b0;
      repeat (TMO) tick();
      chk("err_before_limit", err_timeout, 0);
      tick();
      chk("err_set", err_timeout, 1);
      t_done = now - 1;
      repeat (5) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      step_pkt(7, 0, 1'b1, kind);
      chk("retry_is_video", kind, 0);
      chk("retry_addr_kept", addr_a, 1600);
      chk("err_sticky", err_timeout, 1);

      finish_run();
   end

endmodule
